// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: SEGS 16-bit segments, one segment per stage, global-stall handshake.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output 'ovf'.
module cla_pipe_adder #(
  parameter int SEGS    = 2,
  parameter int OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*SEGS-1:0]   a,
  input  logic [16*SEGS-1:0]   b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*SEGS-1:0]   sum,
  output logic                 cout,
  output logic                 px,
  output logic                 gx
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W = 16 * SEGS;

  if (OUT_REG != 1) begin : g_out_reg_check
    $error("cla_pipe_adder: OUT_REG=0 is not supported");
  end
  if (SEGS < 1 || SEGS > 8) begin : g_segs_check
    $error("cla_pipe_adder: SEGS must be in 1..8");
  end

  // 16-bit two-level lookahead: returns {Pseg, Gseg, carry-out, sum[15:0]}.
  function automatic logic [18:0] cla16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [15:0] p, g, c;
    logic [3:0]  gp, gg, gc;
    logic        pseg, gseg;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
    pseg  = &gp;
    gseg  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {pseg, gseg, gseg | (pseg & ci), p ^ c};
  endfunction

  // Stage k register holds the beat before segment k is added; full-width copies carry skew and de-skew data.
  logic [SEGS-1:0] v_q, c_q, px_q, gx_q;
  logic [W-1:0]    a_q [SEGS];
  logic [W-1:0]    b_q [SEGS];
  logic [W-1:0]    s_q [SEGS];
  logic [18:0]     seg_res  [SEGS];
  logic [W-1:0]    word_nxt [SEGS];
  logic            advance;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < SEGS; k++) begin
      seg_res[k]  = cla16(a_q[k][16*k +: 16], b_q[k][16*k +: 16], c_q[k]);
      word_nxt[k] = s_q[k];
      word_nxt[k][16*k +: 16] = seg_res[k][15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      c_q       <= '0;
      px_q      <= '0;
      gx_q      <= '0;
      for (int k = 0; k < SEGS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      px        <= 1'b0;
      gx        <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (advance) begin
      v_q[0]  <= in_valid;
      a_q[0]  <= a;
      b_q[0]  <= sub ? ~b : b;
      c_q[0]  <= sub | cin;
      px_q[0] <= 1'b1;
      gx_q[0] <= 1'b0;
      s_q[0]  <= '0;
      for (int k = 0; k < SEGS - 1; k++) begin
        v_q[k+1]  <= v_q[k];
        a_q[k+1]  <= a_q[k];
        b_q[k+1]  <= b_q[k];
        s_q[k+1]  <= word_nxt[k];
        c_q[k+1]  <= seg_res[k][16];
        px_q[k+1] <= px_q[k] & seg_res[k][18];
        gx_q[k+1] <= seg_res[k][17] | (seg_res[k][18] & gx_q[k]);
      end
      out_valid <= v_q[SEGS-1];
      // Result registers only load on a real beat so they keep their last value across bubbles.
      if (v_q[SEGS-1]) begin
        sum  <= word_nxt[SEGS-1];
        cout <= seg_res[SEGS-1][16];
        px   <= px_q[SEGS-1] & seg_res[SEGS-1][18];
        gx   <= seg_res[SEGS-1][17] | (seg_res[SEGS-1][18] & gx_q[SEGS-1]);
`ifdef CLA_PIPE_OVF_EN
        ovf  <= seg_res[SEGS-1][16]
              ^ (a_q[SEGS-1][W-1] ^ b_q[SEGS-1][W-1] ^ word_nxt[SEGS-1][W-1]);
`endif
      end
    end
  end

endmodule
